// File: rtl/tile_pixel_fetcher_pkg.sv
// Shared tile types, raster timing and fetch FSM encoding for the tile pixel path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tile_pkg;

    localparam int TILE_W   = 8;
    localparam int TILE_H   = 16;
    localparam int MAP_COLS = 80;

    localparam logic [9:0] H_ACTIVE   = 10'd640;
    localparam logic [9:0] H_TOTAL    = 10'd800;
    localparam logic [9:0] V_ACTIVE   = 10'd480;
    localparam logic [9:0] V_TOTAL    = 10'd525;
    localparam logic [9:0] FETCH_LEAD = 10'd5;

    typedef enum logic [3:0] {
        FLOOR       = 4'd0,
        WALL        = 4'd1,
        RED_DOOR    = 4'd2,
        BLUE_DOOR   = 4'd3,
        LAVA        = 4'd4,
        WATER       = 4'd5,
        PLATE       = 4'd6,
        PUZZLE_DOOR = 4'd7,
        BACKGROUND  = 4'd8
    } tile_id_t;

    typedef enum logic [1:0] {
        FETCH_IDLE     = 2'd0,
        FETCH_MAP_REQ  = 2'd1,
        FETCH_MAP_WAIT = 2'd2,
        FETCH_ROM_CAP  = 2'd3
    } fetch_state_t;

    // row*80 + col built from shifts so no multiplier is implied
    function automatic logic [11:0] map_index(input logic [5:0] trow, input logic [6:0] col);
        return {trow, 6'b0} + {2'b0, trow, 4'b0} + {5'b0, col};
    endfunction

endpackage

// File: rtl/tile_row_shifter.sv
// Staging register for one prefetched glyph row plus the 8-bit pixel shifter and tile register.
// Latency: capture/mark/load/shift each take effect on the next Clk edge.
// Backpressure: none; an empty staging register loads as a blank tile.
module tile_row_shifter
    import tile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic [TILE_W-1:0] cap_row,
    input  logic [3:0]        cap_tile,
    input  logic              mark_en,
    input  logic              load_en,
    input  logic              shift_en,
    output logic              shift_msb,
    output logic [3:0]        tile_q
);

    logic [TILE_W-1:0] stage_row;
    logic [3:0]        stage_tile;
    logic              stage_vld;
    logic [TILE_W-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_row  <= '0;
            stage_tile <= '0;
            stage_vld  <= 1'b0;
            shift_q    <= '0;
            tile_q     <= '0;
        end else begin
            if (cap_en) begin
                stage_row  <= cap_row;
                stage_tile <= cap_tile;
            end
            if (mark_en) begin
                stage_vld <= 1'b1;
            end else if (load_en) begin
                stage_vld <= 1'b0;
            end
            if (load_en) begin
                shift_q <= stage_vld ? stage_row  : '0;
                tile_q  <= stage_vld ? stage_tile : 4'd0;
            end else if (shift_en) begin
                shift_q <= {shift_q[TILE_W-2:0], 1'b0};
            end
        end
    end

    assign shift_msb = shift_q[TILE_W-1];

endmodule

// File: rtl/tile_pixel_fetcher.sv
// Walks the raster, fetches tile ID and glyph row one tile ahead, streams 1 bpp pixels.
// Latency: pixel outputs are registered exactly 1 Clk after each pix_en.
// Backpressure: none; a fetch trigger while busy is dropped and flags fetch_overrun.
module tile_pixel_fetcher
    import tile_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pix_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [11:0] map_addr,
    input  logic [3:0]  map_data,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        pix_on,
    output logic [3:0]  pix_tile,
    output logic        pix_active,
    output logic        fetch_overrun
);

    fetch_state_t state;
    logic [3:0]   glyph_row;

    logic         same_line;
    logic         next_line;
    logic [9:0]   tgt_line;
    logic [6:0]   tgt_col;
    logic         trig;
    logic         load;
    logic         shift;
    logic         vis;
    logic         shift_msb;
    logic [3:0]   tile_q;

    always_comb begin
        same_line = (DrawX < (H_ACTIVE - FETCH_LEAD)) && (DrawX[2:0] == 3'd3);
        next_line = (DrawX == (H_TOTAL - FETCH_LEAD));
        tgt_line  = DrawY;
        tgt_col   = DrawX[9:3] + 7'd1;
        if (next_line) begin
            tgt_line = (DrawY == (V_TOTAL - 10'd1)) ? 10'd0 : DrawY + 10'd1;
            tgt_col  = 7'd0;
        end
        trig  = pix_en && (same_line || next_line) && (tgt_line < V_ACTIVE);
        load  = pix_en && ((DrawX[2:0] == 3'd7) || (DrawX == (H_TOTAL - 10'd1)));
        shift = pix_en && !load;
        vis   = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE);
    end

    // map_data is only meaningful in MAP_WAIT, so the ROM sees 0 otherwise
    assign rom_addr = (state == FETCH_MAP_WAIT) ? {map_data, glyph_row} : 8'd0;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= FETCH_IDLE;
            map_addr      <= '0;
            glyph_row     <= '0;
            fetch_overrun <= 1'b0;
            pix_on        <= 1'b0;
            pix_tile      <= '0;
            pix_active    <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (trig) begin
                        map_addr  <= map_index(tgt_line[9:4], tgt_col);
                        glyph_row <= tgt_line[3:0];
                        state     <= FETCH_MAP_REQ;
                    end
                end
                FETCH_MAP_REQ:  state <= FETCH_MAP_WAIT;
                FETCH_MAP_WAIT: state <= FETCH_ROM_CAP;
                FETCH_ROM_CAP:  state <= FETCH_IDLE;
                default:        state <= FETCH_IDLE;
            endcase
            if (trig && (state != FETCH_IDLE)) begin
                fetch_overrun <= 1'b1;
            end
            if (pix_en) begin
                pix_active <= vis;
                pix_on     <= vis & shift_msb;
                pix_tile   <= vis ? tile_q : 4'd0;
            end
        end
    end

    tile_row_shifter u_shifter (
        .clk       (Clk),
        .rst       (Reset),
        .cap_en    (state == FETCH_MAP_WAIT),
        .cap_row   (rom_data),
        .cap_tile  (map_data),
        .mark_en   (state == FETCH_ROM_CAP),
        .load_en   (load),
        .shift_en  (shift),
        .shift_msb (shift_msb),
        .tile_q    (tile_q)
    );

endmodule
